// File: rtl/int_div_pkg.sv
// Shared types and constants for the iterative divider and its register-file write port.
package int_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    WR_QUOT = 2'd2,
    WR_REM  = 2'd3
  } div_state_e;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_REG_SEL_WIDTH = 5;

  // Selector value meaning "x0": the result is computed but not written.
  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/int_divrem_regfile_if.sv
// Request side (operands, selectors) and register-file write port of the divider.
interface int_divrem_regfile_if
  import int_div_pkg::*;
#(
  parameter int unsigned data_width    = DEF_DATA_WIDTH,
  parameter int unsigned reg_sel_width = DEF_REG_SEL_WIDTH
) ();
  logic                     req;
  logic                     is_signed;
  logic [reg_sel_width-1:0] r_quot_sel;
  logic [reg_sel_width-1:0] r_mod_sel;
  logic [data_width-1:0]    a;
  logic [data_width-1:0]    b;
  logic                     busy;
  logic                     rf_wr_req;
  logic [reg_sel_width-1:0] rf_wr_sel;
  logic [data_width-1:0]    rf_wr_data;
  logic                     rf_wr_ack;

  modport master (
    output req, is_signed, r_quot_sel, r_mod_sel, a, b, rf_wr_ack,
    input  busy, rf_wr_req, rf_wr_sel, rf_wr_data
  );

  modport slave (
    input  req, is_signed, r_quot_sel, r_mod_sel, a, b, rf_wr_ack,
    output busy, rf_wr_req, rf_wr_sel, rf_wr_data
  );
endinterface

// File: rtl/int_div_step.sv
// Combinational restoring-division step: shifts in bits_per_cycle dividend bits (MSB first)
// and retires the same number of quotient bits.
module int_div_step #(
  parameter int unsigned data_width     = 32,
  parameter int unsigned bits_per_cycle = 1
) (
  input  logic [data_width-1:0]     rem_i,
  input  logic [data_width-1:0]     div_i,
  input  logic [bits_per_cycle-1:0] bits_i,
  output logic [data_width-1:0]     rem_o,
  output logic [bits_per_cycle-1:0] quot_o
);
  // One guard bit: the shifted remainder can reach 2*divisor-1.
  logic [data_width:0] r;

  always_comb begin
    r      = {1'b0, rem_i};
    quot_o = '0;
    for (int unsigned k = 0; k < bits_per_cycle; k++) begin
      r = {r[data_width-1:0], bits_i[bits_per_cycle-1-k]};
      if (r >= {1'b0, div_i}) begin
        r                             = r - {1'b0, div_i};
        quot_o[bits_per_cycle-1-k]    = 1'b1;
      end
    end
    rem_o = r[data_width-1:0];
  end
endmodule

// File: rtl/int_divrem_regfile.sv
// Iterative signed/unsigned integer divider writing quotient then remainder back
// through a single req/ack register-file port.
module int_divrem_regfile
  import int_div_pkg::*;
#(
  parameter int unsigned data_width     = DEF_DATA_WIDTH,
  parameter int unsigned reg_sel_width  = DEF_REG_SEL_WIDTH,
  parameter int unsigned bits_per_cycle = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  int_divrem_regfile_if.slave   bus
);
  localparam int unsigned              ITERS    = data_width / bits_per_cycle;
  localparam int unsigned              CNT_W    = $clog2(ITERS) + 1;
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [data_width-1:0]    ONE      = data_width'(1);
  localparam logic [data_width-1:0]    MOST_NEG = {1'b1, {(data_width-1){1'b0}}};
  localparam logic [reg_sel_width-1:0] SEL_X0   = reg_sel_width'(REG_X0);

  div_state_e               state_q;
  logic                     busy_q;
  logic                     wr_req_q;
  logic [reg_sel_width-1:0] wr_sel_q;
  logic [data_width-1:0]    wr_data_q;
  logic [data_width-1:0]    quot_q;
  logic [data_width-1:0]    rem_q;
  logic [data_width-1:0]    div_q;
  logic                     neg_quot_q;
  logic                     neg_rem_q;
  logic [reg_sel_width-1:0] quot_sel_q;
  logic [reg_sel_width-1:0] mod_sel_q;
  logic [CNT_W-1:0]         cnt_q;

  logic                     a_neg, b_neg, div_zero, overflow;
  logic [data_width-1:0]    a_mag, b_mag, fast_quot, fast_rem;
  logic [data_width-1:0]    step_rem, quot_next, fin_quot, fin_rem;
  logic [bits_per_cycle-1:0] step_quot;

  always_comb begin
    a_neg     = bus.is_signed & bus.a[data_width-1];
    b_neg     = bus.is_signed & bus.b[data_width-1];
    a_mag     = a_neg ? (~bus.a + ONE) : bus.a;
    b_mag     = b_neg ? (~bus.b + ONE) : bus.b;
    div_zero  = (bus.b == '0);
    overflow  = bus.is_signed && (bus.a == MOST_NEG) && (bus.b == '1);
    fast_quot = div_zero ? '1 : bus.a;
    fast_rem  = div_zero ? bus.a : '0;
  end

  // quot_q starts as the dividend magnitude and fills with quotient bits from the bottom.
  int_div_step #(
    .data_width     (data_width),
    .bits_per_cycle (bits_per_cycle)
  ) u_step (
    .rem_i  (rem_q),
    .div_i  (div_q),
    .bits_i (quot_q[data_width-1 -: bits_per_cycle]),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  always_comb begin
    quot_next = {quot_q[data_width-bits_per_cycle-1:0], step_quot};
    fin_quot  = neg_quot_q ? (~quot_next + ONE) : quot_next;
    fin_rem   = neg_rem_q  ? (~step_rem + ONE)  : step_rem;
  end

  // First write of a result pair: fast path sources from inputs in IDLE, normal path from CALC.
  div_state_e               launch_state_d;
  logic                     launch_req_d;
  logic [reg_sel_width-1:0] launch_sel_d;
  logic [data_width-1:0]    launch_data_d;
  logic [reg_sel_width-1:0] seq_qsel, seq_msel;
  logic [data_width-1:0]    seq_quot, seq_rem;

  always_comb begin
    seq_qsel       = (state_q == IDLE) ? bus.r_quot_sel : quot_sel_q;
    seq_msel       = (state_q == IDLE) ? bus.r_mod_sel  : mod_sel_q;
    seq_quot       = (state_q == IDLE) ? fast_quot      : fin_quot;
    seq_rem        = (state_q == IDLE) ? fast_rem       : fin_rem;
    launch_state_d = IDLE;
    launch_req_d   = 1'b0;
    launch_sel_d   = '0;
    launch_data_d  = '0;
    if (seq_qsel != SEL_X0) begin
      launch_state_d = WR_QUOT;
      launch_req_d   = 1'b1;
      launch_sel_d   = seq_qsel;
      launch_data_d  = seq_quot;
    end else if (seq_msel != SEL_X0) begin
      launch_state_d = WR_REM;
      launch_req_d   = 1'b1;
      launch_sel_d   = seq_msel;
      launch_data_d  = seq_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_sel_q <= '0;
      mod_sel_q  <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            quot_sel_q <= bus.r_quot_sel;
            mod_sel_q  <= bus.r_mod_sel;
            if (div_zero || overflow) begin
              quot_q    <= fast_quot;
              rem_q     <= fast_rem;
              state_q   <= launch_state_d;
              busy_q    <= launch_req_d;
              wr_req_q  <= launch_req_d;
              wr_sel_q  <= launch_sel_d;
              wr_data_q <= launch_data_d;
            end else begin
              quot_q     <= a_mag;
              rem_q      <= '0;
              div_q      <= b_mag;
              neg_quot_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              cnt_q      <= CNT_LAST;
              busy_q     <= 1'b1;
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          cnt_q  <= cnt_q - 1'b1;
          quot_q <= quot_next;
          rem_q  <= step_rem;
          if (cnt_q == '0) begin
            quot_q    <= fin_quot;
            rem_q     <= fin_rem;
            state_q   <= launch_state_d;
            busy_q    <= launch_req_d;
            wr_req_q  <= launch_req_d;
            wr_sel_q  <= launch_sel_d;
            wr_data_q <= launch_data_d;
          end
        end
        WR_QUOT: begin
          if (bus.rf_wr_ack) begin
            if (mod_sel_q != SEL_X0) begin
              state_q   <= WR_REM;
              wr_sel_q  <= mod_sel_q;
              wr_data_q <= rem_q;
            end else begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              wr_req_q  <= 1'b0;
              wr_sel_q  <= '0;
              wr_data_q <= '0;
            end
          end
        end
        WR_REM: begin
          if (bus.rf_wr_ack) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.rf_wr_req  = wr_req_q;
  assign bus.rf_wr_sel  = wr_sel_q;
  assign bus.rf_wr_data = wr_data_q;
endmodule
